mem_port_arbiter: RTL and testbench

Shares the single-port parameter RAM between two requesters. The host requester is memif, driven from the SPI slave. The DSP requester is the real-time coefficient fetch engine.
- DSP has fixed priority by default.
- A wait counter guarantees the host a slot after a bounded stall.
- A lock input lets the DSP hold exclusive access during critical sections.
- Read data is returned with a registered valid, tagged back to the requester that issued the read.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 77 +++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the parameter-RAM port arbiter: read-return owner tag,
// the bus-level request record and the owner selection helper.
package mem_port_arbiter_pkg;

  localparam int unsigned MemWordWidth = 8;
  localparam int unsigned MemAddrWidth = 2;

  // Who the word coming back from the RAM next cycle belongs to
  typedef enum logic [1:0] {
    RdNone = 2'd0,
    RdHost = 2'd1,
    RdDsp  = 2'd2
  } rd_owner_e;

  // One requester access at the default bus widths
  typedef struct packed {
    logic                    we;
    logic [MemAddrWidth-1:0] addr;
    logic [MemWordWidth-1:0] wdata;
  } mem_req_t;

  // Tag for the read issued this cycle; host writes return nothing
  function automatic rd_owner_e rd_owner_next(input logic dsp_gnt, input logic host_gnt,
                                              input logic host_we);
    if (dsp_gnt) begin
      return RdDsp;
    end
    if (host_gnt && !host_we) begin
      return RdHost;
    end
    return RdNone;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Host, DSP and RAM-side signals of the parameter-RAM arbiter.
// master: requesters plus RAM (environment side); slave: the arbiter itself.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MemWordWidth,
  parameter int unsigned ADDR_WIDTH = MemAddrWidth
);

  // Host requester (memif behind the SPI slave)
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [WORD_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [WORD_WIDTH-1:0] host_rdata;

  // DSP coefficient fetch engine (read only)
  logic                  dsp_req;
  logic [ADDR_WIDTH-1:0] dsp_addr;
  logic                  dsp_lock;
  logic                  dsp_gnt;
  logic                  dsp_rvalid;
  logic [WORD_WIDTH-1:0] dsp_rdata;

  // Single-port RAM with registered read data
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    output dsp_req, dsp_addr, dsp_lock,
    output mem_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  dsp_gnt, dsp_rvalid, dsp_rdata,
    input  mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    input  dsp_req, dsp_addr, dsp_lock,
    input  mem_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output dsp_gnt, dsp_rvalid, dsp_rdata,
    output mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port parameter RAM.
// The DSP wins by default; a saturating wait counter hands the host the port
// after MAX_HOST_WAIT refused cycles, and dsp_lock shuts the host out entirely.
// Read data is passed straight from the RAM and qualified by a per-requester
// valid that is registered alongside the RAM's own read register.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = MemWordWidth,
  parameter int unsigned ADDR_WIDTH    = MemAddrWidth,
  parameter int unsigned MAX_HOST_WAIT = 4
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave io_bus
);

  localparam int unsigned WAIT_WIDTH = $clog2(MAX_HOST_WAIT + 1);
  localparam logic [WAIT_WIDTH-1:0] WaitMax = WAIT_WIDTH'(MAX_HOST_WAIT);

  logic                  w_host_force;
  logic                  w_host_gnt;
  logic                  w_dsp_gnt;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [WORD_WIDTH-1:0] w_mem_wdata;

  logic [WAIT_WIDTH-1:0] r_wait_cnt;
  rd_owner_e             r_rd_owner;

  // Grant decision: DSP first unless the host has waited long enough; lock blocks the host
  always_comb begin
    w_host_force = (r_wait_cnt == WaitMax) && !io_bus.dsp_lock;
    w_dsp_gnt    = reset_n && io_bus.dsp_req && !w_host_force;
    w_host_gnt   = reset_n && io_bus.host_req && !io_bus.dsp_lock &&
                   (!io_bus.dsp_req || w_host_force);
  end

  // RAM port steering: the host address is the idle default, only the host writes
  always_comb begin
    w_mem_addr  = w_dsp_gnt ? io_bus.dsp_addr : io_bus.host_addr;
    w_mem_we    = w_host_gnt && io_bus.host_we;
    w_mem_wdata = io_bus.host_wdata;
  end

  // Count refused host cycles; frozen under lock, cleared once the host is served or gives up
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (!io_bus.host_req || w_host_gnt) begin
      r_wait_cnt <= '0;
    end else if (!io_bus.dsp_lock && (r_wait_cnt != WaitMax)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Remember who issued this cycle's read so the returning word is tagged correctly
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_owner <= RdNone;
    end else begin
      r_rd_owner <= rd_owner_next(w_dsp_gnt, w_host_gnt, io_bus.host_we);
    end
  end

  assign io_bus.host_gnt    = w_host_gnt;
  assign io_bus.dsp_gnt     = w_dsp_gnt;
  assign io_bus.mem_addr    = w_mem_addr;
  assign io_bus.mem_we      = w_mem_we;
  assign io_bus.mem_wdata   = w_mem_wdata;

  assign io_bus.host_rvalid = (r_rd_owner == RdHost);
  assign io_bus.dsp_rvalid  = (r_rd_owner == RdDsp);
  assign io_bus.host_rdata  = io_bus.mem_rdata;
  assign io_bus.dsp_rdata   = io_bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run, all
// checked against a cycle model that tracks the host's stall count, a shadow
// copy of the RAM and the expected read returns.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned WW   = 8;
  localparam int unsigned AW   = 2;
  localparam int unsigned MAXW = 4;

  logic clk;
  logic reset_n;

  mem_port_arbiter_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(
    .WORD_WIDTH   (WW),
    .ADDR_WIDTH   (AW),
    .MAX_HOST_WAIT(MAXW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with a registered read port
  logic [WW-1:0] ram [4];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_err;
  int n_chk;

  // Reference model state
  int unsigned m_stall;
  logic [WW-1:0] m_mem [4];
  bit          m_hrv, m_drv;
  logic [WW-1:0] m_rdata;
  bit          exp_hg, exp_dg, exp_we;
  logic [AW-1:0] exp_addr;

  // Expected combinational outputs for the inputs currently applied
  task automatic model_eval();
    bit host_turn, dsp_first;
    host_turn = (m_stall >= MAXW) && !bus.dsp_lock;
    dsp_first = bus.dsp_req && !host_turn;
    exp_dg    = reset_n && dsp_first;
    exp_hg    = reset_n && bus.host_req && !bus.dsp_lock && !dsp_first;
    exp_we    = exp_hg && bus.host_we;
    exp_addr  = exp_dg ? bus.dsp_addr : bus.host_addr;
  endtask

  // Effect of the coming clock edge on the model
  task automatic model_commit();
    m_rdata = m_mem[exp_addr];
    m_hrv   = exp_hg && !bus.host_we;
    m_drv   = exp_dg;
    if (exp_we) m_mem[bus.host_addr] = bus.host_wdata;
    if (!reset_n || !bus.host_req || exp_hg) m_stall = 0;
    else if (!bus.dsp_lock) m_stall = (m_stall < MAXW) ? m_stall + 1 : MAXW;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_host(input logic req, input mem_req_t r);
    bus.host_req   = req;
    bus.host_we    = r.we;
    bus.host_addr  = r.addr;
    bus.host_wdata = r.wdata;
  endtask

  task automatic idle_cycle();
    bus.host_req = 1'b0;
    bus.dsp_req  = 1'b0;
    @(negedge clk);
    model_eval();
    model_commit();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_host(1'b1, '{we: 1'b0, addr: 2'd1, wdata: 8'h00});
    bus.dsp_req  = 1'b1;
    bus.dsp_addr = 2'd0;
    bus.dsp_lock = 1'b0;
    repeat (3) begin
      @(negedge clk);
      model_eval();
      n_chk++; if (bus.host_gnt !== exp_hg) begin n_err++;
        $display("FAIL rst_host_gnt: got %b want %b", bus.host_gnt, exp_hg); end
      n_chk++; if (bus.dsp_gnt !== exp_dg) begin n_err++;
        $display("FAIL rst_dsp_gnt: got %b want %b", bus.dsp_gnt, exp_dg); end
      n_chk++; if (bus.mem_we !== exp_we) begin n_err++;
        $display("FAIL rst_mem_we: got %b want %b", bus.mem_we, exp_we); end
      n_chk++; if ({bus.host_rvalid, bus.dsp_rvalid} !== {m_hrv, m_drv}) begin n_err++;
        $display("FAIL rst_rvalid: got %b%b want %b%b", bus.host_rvalid, bus.dsp_rvalid,
                 m_hrv, m_drv); end
      model_commit();
      tick();
    end
    reset_n = 1'b1;
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.dsp_gnt !== 1'b1) begin n_err++;
      $display("FAIL rel_dsp_gnt: got %b want 1", bus.dsp_gnt); end
    n_chk++; if (bus.host_gnt !== exp_hg) begin n_err++;
      $display("FAIL rel_host_gnt: got %b want %b", bus.host_gnt, exp_hg); end
    model_commit();
    tick();
    idle_cycle();
  endtask

  task automatic test_priority();
    int hcyc;
    logic [WW-1:0] want;
    hcyc = 0;
    want = m_mem[1];
    drive_host(1'b1, '{we: 1'b0, addr: 2'd1, wdata: 8'h00});
    bus.dsp_req = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      bus.dsp_addr = AW'($urandom);
      @(negedge clk);
      model_eval();
      n_chk++; if ({bus.host_gnt, bus.dsp_gnt} !== {exp_hg, exp_dg}) begin n_err++;
        $display("FAIL prio_gnt c%0d: got %b%b want %b%b", cyc, bus.host_gnt, bus.dsp_gnt,
                 exp_hg, exp_dg); end
      if (bus.host_gnt === 1'b1) hcyc = cyc;
      model_commit();
      tick();
      if (hcyc != 0) break;
    end
    n_chk++; if (hcyc != int'(MAXW + 1)) begin n_err++;
      $display("FAIL prio_host_slot: got cycle %0d want %0d", hcyc, MAXW + 1); end
    bus.host_req = 1'b0;
    bus.dsp_req  = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.host_rvalid !== 1'b1 || bus.dsp_rvalid !== 1'b0) begin n_err++;
      $display("FAIL prio_rvalid: got h%b d%b want h1 d0", bus.host_rvalid, bus.dsp_rvalid); end
    n_chk++; if (bus.host_rdata !== want) begin n_err++;
      $display("FAIL prio_rdata: got %h want %h", bus.host_rdata, want); end
    model_commit();
    tick();
  endtask

  task automatic test_write_readback();
    drive_host(1'b1, '{we: 1'b1, addr: 2'd2, wdata: 8'hA5});
    bus.dsp_req = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.host_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin n_err++;
      $display("FAIL wr_gnt_we: got g%b we%b want g1 we1", bus.host_gnt, bus.mem_we); end
    n_chk++; if (bus.mem_addr !== 2'd2 || bus.mem_wdata !== 8'hA5) begin n_err++;
      $display("FAIL wr_bus: got a%h d%h want a2 dA5", bus.mem_addr, bus.mem_wdata); end
    model_commit();
    tick();
    bus.host_req = 1'b0;
    bus.dsp_req  = 1'b1;
    bus.dsp_addr = 2'd2;
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.mem_we !== 1'b0 || bus.dsp_gnt !== 1'b1) begin n_err++;
      $display("FAIL rd_gnt: got we%b g%b want we0 g1", bus.mem_we, bus.dsp_gnt); end
    model_commit();
    tick();
    bus.dsp_req = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.dsp_rvalid !== 1'b1 || bus.host_rvalid !== 1'b0) begin n_err++;
      $display("FAIL rb_rvalid: got d%b h%b want d1 h0", bus.dsp_rvalid, bus.host_rvalid); end
    n_chk++; if (bus.dsp_rdata !== 8'hA5) begin n_err++;
      $display("FAIL rb_rdata: got %h want a5", bus.dsp_rdata); end
    model_commit();
    tick();
  endtask

  task automatic test_lock();
    int hg_cnt, hcyc;
    hg_cnt = 0;
    hcyc   = 0;
    drive_host(1'b1, '{we: 1'b0, addr: 2'd3, wdata: 8'h00});
    bus.dsp_lock = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.dsp_req  = 1'($urandom);
      bus.dsp_addr = AW'($urandom);
      @(negedge clk);
      model_eval();
      if (bus.host_gnt === 1'b1) hg_cnt++;
      n_chk++; if (bus.dsp_gnt !== exp_dg) begin n_err++;
        $display("FAIL lock_dsp_gnt c%0d: got %b want %b", cyc, bus.dsp_gnt, exp_dg); end
      model_commit();
      tick();
    end
    n_chk++; if (hg_cnt != 0) begin n_err++;
      $display("FAIL lock_host_gnt: got %0d grants want 0", hg_cnt); end
    bus.dsp_lock = 1'b0;
    bus.dsp_req  = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      model_eval();
      if (bus.host_gnt === 1'b1) hcyc = cyc;
      model_commit();
      tick();
      if (hcyc != 0) break;
    end
    n_chk++; if (hcyc != int'(MAXW + 1)) begin n_err++;
      $display("FAIL unlock_host_slot: got cycle %0d want %0d", hcyc, MAXW + 1); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive_host(1'b1, '{we: 1'b0, addr: 2'd0, wdata: 8'h00});
    bus.dsp_req = 1'b0;
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.host_gnt !== 1'b1) begin n_err++;
      $display("FAIL mid_gnt: got %b want 1", bus.host_gnt); end
    #2;
    reset_n = 1'b0;
    #1;
    model_eval();
    n_chk++; if (bus.host_gnt !== exp_hg) begin n_err++;
      $display("FAIL mid_gnt_forced: got %b want %b", bus.host_gnt, exp_hg); end
    model_commit();
    tick();
    @(negedge clk);
    model_eval();
    n_chk++; if (bus.host_rvalid !== 1'b0) begin n_err++;
      $display("FAIL mid_rvalid: got %b want 0", bus.host_rvalid); end
    model_commit();
    tick();
    reset_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] want [4];
    for (int i = 0; i < 4; i++) want[i] = m_mem[i];
    bus.host_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.dsp_req  = (i < 4);
      bus.dsp_addr = AW'(i);
      @(negedge clk);
      model_eval();
      n_chk++; if (bus.dsp_gnt !== 1'(i < 4)) begin n_err++;
        $display("FAIL b2b_gnt %0d: got %b want %b", i, bus.dsp_gnt, i < 4); end
      n_chk++; if (bus.dsp_rvalid !== 1'(i >= 1 && i <= 4) || bus.host_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_rvalid %0d: got d%b h%b", i, bus.dsp_rvalid, bus.host_rvalid); end
      if (i >= 1 && i <= 4) begin
        n_chk++; if (bus.dsp_rdata !== want[i-1]) begin n_err++;
          $display("FAIL b2b_rdata %0d: got %h want %h", i, bus.dsp_rdata, want[i-1]); end
      end
      model_commit();
      tick();
    end
  endtask

  task automatic test_random();
    bit h_hold, d_hold;
    h_hold = 1'b0;
    d_hold = 1'b0;
    bus.dsp_lock = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!h_hold) drive_host(($urandom_range(0, 2) != 0),
                              '{we: 1'($urandom), addr: AW'($urandom), wdata: WW'($urandom)});
      if (!d_hold) begin
        bus.dsp_req  = ($urandom_range(0, 3) != 0);
        bus.dsp_addr = AW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.dsp_lock = ~bus.dsp_lock;
      @(negedge clk);
      model_eval();
      n_chk++; if ({bus.host_gnt, bus.dsp_gnt} !== {exp_hg, exp_dg}) begin n_err++;
        $display("FAIL rnd_gnt c%0d: got %b%b want %b%b", cyc, bus.host_gnt, bus.dsp_gnt,
                 exp_hg, exp_dg); end
      n_chk++; if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr) begin n_err++;
        $display("FAIL rnd_mem c%0d: got we%b a%h want we%b a%h", cyc, bus.mem_we,
                 bus.mem_addr, exp_we, exp_addr); end
      n_chk++; if ({bus.host_rvalid, bus.dsp_rvalid} !== {m_hrv, m_drv}) begin n_err++;
        $display("FAIL rnd_rvalid c%0d: got %b%b want %b%b", cyc, bus.host_rvalid,
                 bus.dsp_rvalid, m_hrv, m_drv); end
      if (m_hrv) begin
        n_chk++; if (bus.host_rdata !== m_rdata) begin n_err++;
          $display("FAIL rnd_hdata c%0d: got %h want %h", cyc, bus.host_rdata, m_rdata); end
      end
      if (m_drv) begin
        n_chk++; if (bus.dsp_rdata !== m_rdata) begin n_err++;
          $display("FAIL rnd_ddata c%0d: got %h want %h", cyc, bus.dsp_rdata, m_rdata); end
      end
      model_commit();
      h_hold = bus.host_req && !exp_hg;
      d_hold = bus.dsp_req && !exp_dg;
      tick();
    end
    bus.dsp_lock = 1'b0;
  endtask

  initial begin
    n_err   = 0;
    n_chk   = 0;
    m_stall = 0;
    m_hrv   = 1'b0;
    m_drv   = 1'b0;
    m_rdata = '0;
    reset_n = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.dsp_req    = 1'b0;
    bus.dsp_addr   = '0;
    bus.dsp_lock   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ram[i]   = WW'(8'h3C + 8'(i * 17));
      m_mem[i] = WW'(8'h3C + 8'(i * 17));
    end
    test_reset();
    test_priority();
    test_write_readback();
    test_lock();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
